// File: rtl/msg_rr_arbiter.sv
// rtl/msg_rr_arbiter.sv - round-robin framer merging N_SRC message sources onto one byte stream
// Define MSG_ARB_CHECKSUM_EN to append an XOR checksum byte to every frame.
module msg_rr_arbiter #(
  parameter int N_SRC = 8,
  parameter int IDX_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   have_msg_bus,
  input  logic [8*N_SRC-1:0] len_bus,
  input  logic [8*N_SRC-1:0] data_bus,
  output logic [N_SRC-1:0]   rdreq_bus,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               pkt_done
);

`ifdef MSG_ARB_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, SUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, LEN, DATA} state_t;
`endif

  state_t             state;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic [IDX_W:0]     start;
  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;
  logic [7:0]         len_q;
  logic [7:0]         cnt_q;
  logic [7:0]         hdr_q;
  logic [7:0]         sel_len;
  logic [7:0]         sel_data;
  logic               xfer;
  logic               final_now;
  logic               pop_en;
`ifdef MSG_ARB_CHECKSUM_EN
  logic [7:0]         sum_q;
`endif

  // Rotate the request vector so bit 0 is the source just after the last grant.
  always_comb begin
    int off;
    int sum_i;
    any_req = 1'b0;
    off     = 0;
    start   = {1'b0, last_q} + {{IDX_W{1'b0}}, 1'b1};
    dbl     = {have_msg_bus, have_msg_bus} >> start;
    rot     = dbl[N_SRC-1:0];
    for (int i = 0; i < N_SRC; i++) begin
      if (!any_req && rot[i]) begin
        any_req = 1'b1;
        off     = i;
      end
    end
    sum_i = int'(last_q) + 1 + off;
    if (sum_i >= N_SRC) sum_i = sum_i - N_SRC;
    pick = IDX_W'(sum_i);
  end

  always_comb begin
    sel_len  = 8'h00;
    sel_data = 8'h00;
    for (int s = 0; s < N_SRC; s++) begin
      if (pick == IDX_W'(s)) sel_len = len_bus[s*8 +: 8];
      if (grant_idx == IDX_W'(s)) sel_data = data_bus[s*8 +: 8];
    end
  end

  assign xfer = tx_valid & tx_ready;

`ifdef MSG_ARB_CHECKSUM_EN
  assign final_now = (state == SUM);
`else
  assign final_now = ((state == LEN) && (len_q == 8'h00)) ||
                     ((state == DATA) && (cnt_q == 8'h01));
`endif

  assign tx_data  = (state == DATA) ? sel_data : hdr_q;
  assign pop_en   = (state == DATA) & tx_ready & ~rst;
  assign pkt_done = xfer & final_now & ~rst;

  always_comb begin
    rdreq_bus = '0;
    for (int s = 0; s < N_SRC; s++) begin
      rdreq_bus[s] = pop_en && (grant_idx == IDX_W'(s));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      hdr_q     <= 8'h00;
      grant_idx <= '0;
      last_q    <= IDX_W'(N_SRC - 1);
      len_q     <= 8'h00;
      cnt_q     <= 8'h00;
`ifdef MSG_ARB_CHECKSUM_EN
      sum_q     <= 8'h00;
`endif
    end else begin
`ifdef MSG_ARB_CHECKSUM_EN
      if (xfer) sum_q <= sum_q ^ tx_data;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ADDR;
            grant_idx <= pick;
            last_q    <= pick;
            len_q     <= sel_len;
            hdr_q     <= 8'(pick);
            tx_valid  <= 1'b1;
            busy      <= 1'b1;
`ifdef MSG_ARB_CHECKSUM_EN
            sum_q     <= 8'h00;
`endif
          end
        end
        ADDR: begin
          if (xfer) begin
            state <= LEN;
            hdr_q <= len_q;
          end
        end
        LEN: begin
          if (xfer) begin
            if (len_q == 8'h00) begin
`ifdef MSG_ARB_CHECKSUM_EN
              state <= SUM;
              hdr_q <= sum_q ^ tx_data;
`else
              state    <= IDLE;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              hdr_q    <= 8'h00;
`endif
            end else begin
              state <= DATA;
              cnt_q <= len_q;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            cnt_q <= cnt_q - 8'h01;
            if (cnt_q == 8'h01) begin
`ifdef MSG_ARB_CHECKSUM_EN
              state <= SUM;
              hdr_q <= sum_q ^ tx_data;
`else
              state    <= IDLE;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              hdr_q    <= 8'h00;
`endif
            end
          end
        end
`ifdef MSG_ARB_CHECKSUM_EN
        SUM: begin
          if (xfer) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            hdr_q    <= 8'h00;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
